// File: rtl/ones_frame_acc.sv
// Frame accumulator for per-value '1'-digit counts: collects up to FRAME_LEN samples
// (or fewer on flush) and presents sum/max/nonzero/length statistics with a valid/ready handshake.
module ones_frame_acc #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_cnt,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [2:0]       out_max,
  output logic [7:0]       out_nz,
  output logic [7:0]       out_len,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // One extra bit above the wider of sum and sample, so the true sum is visible before saturation.
  localparam int              AW       = ((SUM_W > 3) ? SUM_W : 3) + 1;
  localparam logic [AW-1:0]   SUM_MAX  = {{(AW-SUM_W){1'b0}}, {SUM_W{1'b1}}};
  localparam logic [7:0]      LEN_FULL = 8'(FRAME_LEN);

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [2:0]       max_q, max_d;
  logic [7:0]       nz_q, nz_d;
  logic [7:0]       len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [2:0]       out_max_q, out_max_d;
  logic [7:0]       out_nz_q, out_nz_d;
  logic [7:0]       out_len_q, out_len_d;
  logic             out_ovf_q, out_ovf_d;

  logic             xfer;
  logic [SUM_W-1:0] base_sum;
  logic [2:0]       base_max;
  logic [7:0]       base_nz;
  logic [7:0]       base_len;
  logic             base_ovf;
  logic [AW-1:0]    wide_sum;
  logic [SUM_W-1:0] new_sum;
  logic             new_ovf;
  logic [2:0]       new_max;
  logic [7:0]       new_nz;
  logic [7:0]       new_len;

  // Next-state, accumulator update and registered output image.
  always_comb begin
    xfer = in_valid && in_ready_q;

    // A transfer in IDLE starts from an empty frame, so it shares the ACC update path.
    if (state_q == S_IDLE) begin
      base_sum = '0;
      base_max = 3'd0;
      base_nz  = 8'd0;
      base_len = 8'd0;
      base_ovf = 1'b0;
    end else begin
      base_sum = sum_q;
      base_max = max_q;
      base_nz  = nz_q;
      base_len = len_q;
      base_ovf = ovf_q;
    end

    wide_sum = {{(AW-SUM_W){1'b0}}, base_sum} + {{(AW-3){1'b0}}, in_cnt};
    if (wide_sum > SUM_MAX) begin
      new_sum = '1;
      new_ovf = 1'b1;
    end else begin
      new_sum = wide_sum[SUM_W-1:0];
      new_ovf = base_ovf;
    end

    if (in_cnt > base_max) begin
      new_max = in_cnt;
    end else begin
      new_max = base_max;
    end

    if (in_cnt != 3'd0) begin
      new_nz = base_nz + 8'd1;
    end else begin
      new_nz = base_nz;
    end

    new_len = base_len + 8'd1;

    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    nz_d    = nz_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          sum_d   = new_sum;
          max_d   = new_max;
          nz_d    = new_nz;
          len_d   = new_len;
          ovf_d   = new_ovf;
          state_d = flush ? S_HOLD : S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (xfer) begin
          sum_d = new_sum;
          max_d = new_max;
          nz_d  = new_nz;
          len_d = new_len;
          ovf_d = new_ovf;
          if (flush || (new_len == LEN_FULL)) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_ACC;
          end
        end else if (flush) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_ACC;
        end
      end
      S_HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes the handshake.
        if (out_ready) begin
          state_d = S_IDLE;
          sum_d   = '0;
          max_d   = 3'd0;
          nz_d    = 8'd0;
          len_d   = 8'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        sum_d   = '0;
        max_d   = 3'd0;
        nz_d    = 8'd0;
        len_d   = 8'd0;
        ovf_d   = 1'b0;
      end
    endcase

    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);

    if (out_valid_d) begin
      out_sum_d = sum_d;
      out_max_d = max_d;
      out_nz_d  = nz_d;
      out_len_d = len_d;
      out_ovf_d = ovf_d;
    end else begin
      out_sum_d = '0;
      out_max_d = 3'd0;
      out_nz_d  = 8'd0;
      out_len_d = 8'd0;
      out_ovf_d = 1'b0;
    end
  end

  // State, accumulator and output registers; reset discards any partial or pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      max_q       <= 3'd0;
      nz_q        <= 8'd0;
      len_q       <= 8'd0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= 3'd0;
      out_nz_q    <= 8'd0;
      out_len_q   <= 8'd0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      nz_q        <= nz_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_nz_q    <= out_nz_d;
      out_len_q   <= out_len_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_max   = out_max_q;
  assign out_nz    = out_nz_q;
  assign out_len   = out_len_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ones_frame_acc.sv
// Bench for ones_frame_acc: two instances (SUM_W=6 and SUM_W=4) share stimulus and are checked
// against a queue-based frame model at every falling edge.
module tb_ones_frame_acc;

  localparam int FL = 8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_cnt;
  logic       flush;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [5:0] a_out_sum;
  logic [2:0] a_out_max;
  logic [7:0] a_out_nz, a_out_len;

  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [3:0] b_out_sum;
  logic [2:0] b_out_max;
  logic [7:0] b_out_nz, b_out_len;

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cnt(in_cnt), .in_ready(a_in_ready),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum),
    .out_max(a_out_max), .out_nz(a_out_nz), .out_len(a_out_len), .out_ovf(a_out_ovf)
  );

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cnt(in_cnt), .in_ready(b_in_ready),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum),
    .out_max(b_out_max), .out_nz(b_out_nz), .out_len(b_out_len), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is just the list of accepted samples.
  int q[$];
  bit m_hold, m_alive;
  int e_sum6, e_sum4, e_ovf6, e_ovf4, e_max, e_nz, e_len;

  task automatic close_frame();
    int total;
    total = 0; e_max = 0; e_nz = 0;
    foreach (q[i]) begin
      total += q[i];
      if (q[i] > e_max) e_max = q[i];
      if (q[i] != 0) e_nz++;
    end
    e_len  = q.size();
    e_sum6 = (total > 63) ? 63 : total;
    e_ovf6 = (total > 63) ? 1 : 0;
    e_sum4 = (total > 15) ? 15 : total;
    e_ovf4 = (total > 15) ? 1 : 0;
    q.delete();
    m_hold = 1'b1;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      m_hold = 1'b0;
      m_alive = 1'b0;
    end else begin
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (m_alive) begin
        if (in_valid) q.push_back(int'(in_cnt));
        if ((flush && q.size() > 0) || q.size() == FL) close_frame();
      end
      m_alive = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("a_in_ready", a_in_ready, m_alive && !m_hold);
    check_eq("a_out_valid", a_out_valid, m_hold);
    check_eq("a_out_sum", a_out_sum, m_hold ? e_sum6 : 0);
    check_eq("a_out_ovf", a_out_ovf, m_hold ? e_ovf6 : 0);
    check_eq("a_out_max", a_out_max, m_hold ? e_max : 0);
    check_eq("a_out_nz", a_out_nz, m_hold ? e_nz : 0);
    check_eq("a_out_len", a_out_len, m_hold ? e_len : 0);
    check_eq("b_in_ready", b_in_ready, m_alive && !m_hold);
    check_eq("b_out_valid", b_out_valid, m_hold);
    check_eq("b_out_sum", b_out_sum, m_hold ? e_sum4 : 0);
    check_eq("b_out_ovf", b_out_ovf, m_hold ? e_ovf4 : 0);
    check_eq("b_out_len", b_out_len, m_hold ? e_len : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input int c, input bit f);
    in_valid = v;
    in_cnt   = 3'(c);
    flush    = f;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_edge();
    #1;
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_in_ready", a_in_ready, 0);
    check_eq("rst_out_len", a_out_len, 0);
    check_eq("rst_sat_out_valid", b_out_valid, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int s32[8];
    s32 = '{1, 0, 2, 1, 0, 1, 2, 1};
    rst_n = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 1'b0);
    m_hold = 1'b0; m_alive = 1'b0;
    @(negedge clk);
    check_all();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Full frame, one sample per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s32[i], 1'b0);
      step();
    end
    check_eq("r32_valid", a_out_valid, 1);
    check_eq("r32_sum", a_out_sum, 8);
    check_eq("r32_max", a_out_max, 2);
    check_eq("r32_nz", a_out_nz, 6);
    check_eq("r32_len", a_out_len, 8);
    check_eq("r32_ovf", a_out_ovf, 0);
    drive(1'b0, 0, 1'b0);
    step();
    step();

    // Early flush on the third sample.
    drive(1'b1, 2, 1'b0); step();
    drive(1'b1, 1, 1'b0); step();
    drive(1'b1, 0, 1'b1); step();
    check_eq("r33_sum", a_out_sum, 3);
    check_eq("r33_max", a_out_max, 2);
    check_eq("r33_nz", a_out_nz, 2);
    check_eq("r33_len", a_out_len, 3);
    drive(1'b0, 0, 1'b0);
    step();

    // Saturation on the SUM_W=4 instance.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 7, 1'b0);
      step();
    end
    check_eq("r34_sum", b_out_sum, 15);
    check_eq("r34_ovf", b_out_ovf, 1);
    check_eq("r34_len", b_out_len, 8);
    check_eq("r34_wide_sum", a_out_sum, 56);
    drive(1'b0, 0, 1'b0);
    step();

    // Backpressure: result held, inputs ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 1'b0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 3, i[1]);
      step();
      check_eq("r35_in_ready", a_in_ready, 0);
      check_eq("r35_sum", a_out_sum, 28);
    end
    out_ready = 1'b1;
    drive(1'b1, 5, 1'b0);
    step();
    check_eq("r35_exit_valid", a_out_valid, 0);
    drive(1'b0, 0, 1'b0);
    step();

    // Reset mid-frame, then a fresh full frame.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, 1'b0);
      step();
    end
    drive(1'b0, 0, 1'b0);
    do_reset();
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1, 1'b0);
      step();
    end
    check_eq("r36_len", a_out_len, 8);
    check_eq("r36_sum", a_out_sum, 8);
    drive(1'b0, 0, 1'b0);
    step();

    // Flush in IDLE.
    drive(1'b0, 0, 1'b1); step(); step();
    check_eq("r37_no_frame", a_out_valid, 0);
    drive(1'b1, 1, 1'b1); step();
    check_eq("r37_sum", a_out_sum, 1);
    check_eq("r37_len", a_out_len, 1);
    drive(1'b0, 0, 1'b0);
    step();

    // Randomized traffic, including a reset while a result may be pending.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      if (i == 400) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ones_frame_acc.md
ONES_FRAME_ACC -- requirements
Module: ones_frame_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of samples per frame, legal range 2..255.
REQ-002 SHALL have parameter SUM_W, default 6: width of the frame sum output.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_cnt carries a per-value decimal-'1'-digit count.
REQ-006 SHALL have port in_cnt, input, 3: sample value, 0..7.
REQ-007 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-008 SHALL have port flush, input, 1: close the current frame early.
REQ-009 SHALL have port out_valid, output, 1: frame result is presented.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-011 SHALL have port out_sum, output, SUM_W: saturated sum of frame samples.
REQ-012 SHALL have port out_max, output, 3: largest sample in the frame.
REQ-013 SHALL have port out_nz, output, 8: number of nonzero samples in the frame.
REQ-014 SHALL have port out_len, output, 8: number of samples in the frame.
REQ-015 SHALL have port out_ovf, output, 1: out_sum saturated during the frame.

Function
REQ-016 SHALL implement states IDLE (no samples), ACC (1..FRAME_LEN-1 samples), HOLD (result presented).
REQ-017 SHALL define a transfer as in_valid && in_ready at a rising edge; in_ready = 1 in IDLE and ACC and 0 in HOLD.
REQ-018 SHALL, on a transfer in IDLE, load sum=in_cnt, max=in_cnt, nz=(in_cnt!=0), len=1, ovf=0, and go to ACC.
REQ-019 SHALL, on a transfer in ACC, add in_cnt to sum, update max, increment nz if nonzero, and increment len.
REQ-020 SHALL saturate sum at 2^SUM_W-1 and set ovf sticky for the frame when the true sum exceeds that value.
REQ-021 SHALL enter HOLD on the edge where the transfer makes len reach FRAME_LEN, with out_valid high the next cycle (1-cycle latency).
REQ-022 SHALL, when flush is high in ACC, enter HOLD; a same-cycle transfer is included in the frame first.
REQ-023 SHALL, when flush is high in IDLE with a transfer, produce a frame of len=1; flush in IDLE without a transfer is ignored.
REQ-024 SHALL hold out_valid and all out_* stable in HOLD until out_valid && out_ready, then go to IDLE.
REQ-025 SHALL ignore in_valid and flush while in HOLD; no sample is lost because in_ready is low.
REQ-026 SHALL drive out_sum, out_max, out_nz, out_len and out_ovf to 0 whenever out_valid is 0.
REQ-027 SHALL allow out_ready high in the same cycle out_valid first rises, giving a 1-cycle HOLD.
REQ-028 SHALL accept no new sample in the HOLD-exit cycle; the next frame starts in IDLE one cycle later.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force state=IDLE, in_ready=0, out_valid=0, and all accumulators and out_* to 0.
REQ-030 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-031 SHALL discard a partial frame or pending result on reset assertion mid-frame or in HOLD, and produce no output for it.

Verification
REQ-032 SHALL cover a full frame: FRAME_LEN=8, in_cnt 1,0,2,1,0,1,2,1, one per cycle, out_ready=1 -> out_valid 1 cycle after the 8th transfer, sum=8, max=2, nz=6, len=8, ovf=0.
REQ-033 SHALL cover an early flush: in_cnt 2,1,0 with flush on the 3rd transfer -> sum=3, max=2, nz=2, len=3.
REQ-034 SHALL cover saturation: SUM_W=4, FRAME_LEN=8, eight samples of 7 -> sum=15, ovf=1, len=8.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover reset mid-frame: rst_n low after 4 samples -> out_valid=0 immediately; a fresh 8-sample frame after release -> len=8 with no carry-over.
REQ-037 SHALL cover flush in IDLE: flush without in_valid -> no frame; flush with in_valid, in_cnt=1 -> frame with sum=1, len=1.
